// File: rtl/mux_sel_sequencer.sv
// Round-robin select/enable sequencer for a 2:1 pass-transistor mux.
// Each slot holds its grant for DWELL cycles; a select change is preceded by GUARD dead cycles.
module mux_sel_sequencer #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned GUARD = 1,
    parameter int unsigned CW    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic sel,
    output logic en,
    output logic gnt0,
    output logic gnt1,
    output logic slot_done,
    output logic busy
);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_DWELL = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          en_q, en_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          arb;
    logic          target;

    // Next-state logic; outputs are derived from the next state so they register with it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        arb     = 1'b0;
        target  = 1'b0;

        case (state_q)
            S_IDLE: arb = 1'b1;
            S_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = S_DWELL;
                    cnt_d   = DWELL_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DWELL: begin
                if (cnt_q == '0) begin
                    last_d = sel_q;
                    arb    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Tie-break uses the just-updated last_served so back-to-back slots alternate
        if (arb) begin
            if (!req0 && !req1) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                target = (req0 && req1) ? ~last_d : req1;
                if (target == sel_q) begin
                    state_d = S_DWELL;
                    cnt_d   = DWELL_LAST;
                end else begin
                    sel_d   = target;
                    state_d = S_GUARD;
                    cnt_d   = GUARD_LAST;
                end
            end
        end

        en_d   = (state_d == S_DWELL);
        gnt0_d = en_d & ~sel_d;
        gnt1_d = en_d & sel_d;
        done_d = en_d && (cnt_d == '0);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            en_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            en_q    <= en_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sel       = sel_q;
    assign en        = en_q;
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign slot_done = done_q;
    assign busy      = busy_q;

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Time-division select controller that drives the select and enable of the switch-level 2:1 mux. Two request inputs compete for the shared mux output. The block grants them round-robin, holds each grant for a fixed dwell, and inserts break-before-make guard cycles whenever the select changes, so the pass-transistor paths never conduct simultaneously. It sits directly upstream of the mux: `sel` drives the mux select, and `en` gates the mux output onto the consumer.

## Interface
- `DWELL`, default 4: cycles each granted slot lasts; legal range 1..2^CW-1.
- `GUARD`, default 1: cycles with `en`=0 after a select change; legal range 1..2^CW-1.
- `CW`, default 4: width of the internal dwell/guard counter.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req0` input, 1 bit: channel 0 request, level-sensitive.
- `req1` input, 1 bit: channel 1 request, level-sensitive.
- `sel` output, 1 bit: mux select; 0 = i0, 1 = i1.
- `en` output, 1 bit: mux output enable; high only during DWELL.
- `gnt0` output, 1 bit: channel 0 granted; equals `en & ~sel`.
- `gnt1` output, 1 bit: channel 1 granted; equals `en & sel`.
- `slot_done` output, 1 bit: one-cycle pulse on the last DWELL cycle of a slot.
- `busy` output, 1 bit: state != IDLE.

## Operation
- All outputs are registered.
- Reset values: `sel`=0, `en`=0, `gnt0`=0, `gnt1`=0, `slot_done`=0, `busy`=0, state=IDLE, counter=0, last_served=1. With last_served=1, channel 0 wins the first tie.
- States: IDLE, GUARD, DWELL.
- Arbitration point: taken in IDLE on every edge, and in DWELL on the last dwell cycle.
  - One request active: target = that channel.
  - Both requests active: target = ~last_served.
  - No request: go to (or stay in) IDLE.
- Transitions on a won arbitration:
  - target == current `sel`: enter DWELL with counter=DWELL-1; `sel` unchanged.
  - target != current `sel`: `sel`<=target, enter GUARD with counter=GUARD-1, `en`=0.
- GUARD: counter decrements each cycle. When counter==0, go to DWELL with counter=DWELL-1.
- DWELL:
  - `en`=1 and the matching `gnt` is high. Counter decrements each cycle.
  - When counter==0: `slot_done`=1, last_served<=`sel`, then arbitrate.
  - Staying on the same channel keeps `en` high continuously, with no gap.
- A slot is committed once entered: dropping a request during GUARD or DWELL does not shorten it.
- Requests are level-sensitive. A request deasserted before it is sampled is lost. No request queuing.
- `sel` changes only on the edge that enters GUARD, never while `en`=1.
- Reset asserted mid-operation: all outputs and state go to reset values immediately, without waiting for `clk`. No partial slot resumes after release.

## Timing
- Request sampled at edge N in IDLE with target == `sel`: `en`/`gnt` are high from edge N to edge N+DWELL. `slot_done` is high during the last of those cycles.
- Request sampled at edge N with target != `sel`:
  - `sel` flips at edge N.
  - `en`=0 for GUARD cycles.
  - `en` rises at edge N+GUARD and stays high for DWELL cycles.
- Back-to-back alternation:
  - Period = GUARD+DWELL cycles per slot.
  - `en` is low for exactly GUARD cycles between slots.
  - There is no IDLE bubble between slots.
- Same-channel continuation: period = DWELL. `en` never drops. `slot_done` pulses every DWELL cycles.
- Arbitration is one cycle from request to state change. The outputs add no further latency.
- Counter width: DWELL-1 and GUARD-1 must fit in CW bits. Out-of-range parameters are illegal and are not checked by the RTL.

## Test plan
- Reset, with `rst_n`=0 and requests toggling:
  - All outputs stay 0.
  - After release, with `req0`=`req1`=0, `busy` stays 0.
- Single slot, `req0` pulsed for 1 cycle from reset (DWELL=4):
  - `sel` stays 0, with no guard.
  - `gnt0`=`en`=1 for exactly 4 cycles.
  - `slot_done` is high on the 4th of those cycles, then `busy`=0.
- Switch with guard, `req1` held from reset (GUARD=1, DWELL=4):
  - `sel`->1 with `en`=0 for 1 cycle.
  - Then `gnt1`=1 for 4 cycles, repeating every 4 cycles with no further guard.
- Both requests held (GUARD=1, DWELL=4):
  - Grant order 0,1,0,1.
  - Each slot has 4 cycles of `en`=1.
  - Exactly 1 `en`=0 cycle at each `sel` change.
  - `gnt0` and `gnt1` are never high together.
- Request drop mid-slot: `req0` deasserted on the 2nd DWELL cycle.
  - The slot still completes 4 cycles.
  - `slot_done` pulses, then IDLE.
- Reset mid-DWELL on channel 1:
  - `rst_n` low mid-cycle clears `en`, `gnt1` and `sel` before the next edge.
  - After release, with both requests high, channel 0 is granted first and no guard is inserted.
